mem_ctrl_ws: RTL

- Parametrised on-chip RAM slave for the PICO16a bus.
- It supports a configurable base address, data width, depth, and independent read/write wait states.
- It drives a registered `ready` acknowledge and a tri-stated read-data return onto the shared `to_cpu` bus.
- It replaces the fixed 512x16, zero-wait memory slave and can be instantiated several times at different bases.

---
 rtl/mem_ctrl_ws.sv | 98 +++++++++
 1 files changed

// File: rtl/mem_ctrl_ws.sv
// mem_ctrl_ws: PICO16a on-chip RAM slave with base decode, independent read/write
// wait states, a registered ready acknowledge and a tri-stated read return.
//
// state  | meaning
// IDLE   | nothing in flight, requests accepted
// WWAIT  | write committed to RAM, counting down write wait states
// RWAIT  | read data captured, counting down read wait states
// DONE_W | write acknowledge cycle (ready=1, to_cpu=Z)
// DONE_R | read return cycle (ready=1, to_cpu=rdata); new request may be accepted
module mem_ctrl_ws #(
    parameter int                DATA_W  = 16,
    parameter int                ADRS_W  = 16,
    parameter int                MEM_AW  = 9,
    parameter logic [ADRS_W-1:0] BASE    = '0,
    parameter int                RD_WAIT = 0,
    parameter int                WR_WAIT = 0
) (
    input  logic              cpu_clk,
    input  logic              rst,
    input  logic [ADRS_W-1:0] adrs,
    input  logic [DATA_W-1:0] from_cpu,
    input  logic              we,
    input  logic              re,
    output logic [DATA_W-1:0] to_cpu,
    output logic              ready
);
    typedef enum logic [2:0] {IDLE, WWAIT, RWAIT, DONE_W, DONE_R} state_t;

    localparam logic [ADRS_W-MEM_AW-1:0] BASE_TAG = BASE[ADRS_W-1:MEM_AW];
    localparam logic [3:0]               WR_CNT   = 4'(WR_WAIT - 1);
    localparam logic [3:0]               RD_CNT   = 4'(RD_WAIT - 1);

    logic [DATA_W-1:0] mem [2**MEM_AW];
    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] rdata;
    logic              rd_oe;
    logic              cs;
    logic              can_accept;
    logic              acc_wr;
    logic              acc_rd;
    logic [MEM_AW-1:0] idx;

    assign idx        = adrs[MEM_AW-1:0];
    assign cs         = (adrs[ADRS_W-1:MEM_AW] == BASE_TAG);
    assign can_accept = (state == IDLE) || (state == DONE_W) || (state == DONE_R);
    // A simultaneous we/re is a write; re only matters when we is low.
    assign acc_wr     = can_accept && cs && we;
    assign acc_rd     = can_accept && cs && re && !we;

    always_comb begin
        state_nx = state;
        case (state)
            WWAIT: if (cnt == 4'd0) state_nx = DONE_W;
            RWAIT: if (cnt == 4'd0) state_nx = DONE_R;
            default: begin
                if (acc_wr)
                    state_nx = (WR_WAIT == 0) ? DONE_W : WWAIT;
                else if (acc_rd)
                    state_nx = (RD_WAIT == 0) ? DONE_R : RWAIT;
                else
                    state_nx = IDLE;
            end
        endcase
    end

    // ready and rd_oe are decoded from the next state so the outputs come straight off flops.
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rdata <= '0;
            ready <= 1'b0;
            rd_oe <= 1'b0;
        end else begin
            state <= state_nx;
            ready <= (state_nx == DONE_W) || (state_nx == DONE_R);
            rd_oe <= (state_nx == DONE_R);
            if (acc_wr) begin
                cnt <= WR_CNT;
            end else if (acc_rd) begin
                cnt   <= RD_CNT;
                rdata <= mem[idx];
            end else if (((state == WWAIT) || (state == RWAIT)) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!rst && acc_wr)
            mem[idx] <= from_cpu;
    end

    assign to_cpu = rd_oe ? rdata : {DATA_W{1'bz}};

endmodule
